div_row_sequencer: RTL and testbench
====================================

Name: div_row_sequencer

Overview:
- Upstream feeder for the n-lane array divider in the matrix-inverse datapath.
- Accepts one matrix row serially (one 27-bit word per cycle) plus a pivot word.
- Assembles the n-wide dataa vector and broadcasts the pivot to all n datab lanes.
- Drives the divider enable for its fixed latency, captures the n quotients, and streams them out serially with back-pressure.

Parameters:
- N, 15, number of lanes / row length; matches divider n.
- W, 27, word width in bits; values are opaque to this block.
- DIV_LAT, 6, number of enabled clocks from operands presented to result valid.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  begin a row operation; sampled only in IDLE
- pivot  input  W  divisor; latched on accepted start
- in_valid  input  1  row word valid
- in_data  input  W  row word; words arrive in lane order 0..N-1
- in_ready  output  1  high only in LOAD
- div_en  output  1  divider enable
- div_rst  output  1  divider reset
- div_dataa  output  N*W  packed [N-1:0][W-1:0] dividends
- div_datab  output  N*W  packed pivot broadcast
- div_result  input  N*W  divider quotients
- out_valid  output  1  quotient word valid
- out_data  output  W  quotient word
- out_index  output  $clog2(N)  lane index of out_data
- out_ready  input  1  consumer accepts word
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous, active-high (rst). On rst:
  - state goes to IDLE; load, result and lat counters go to 0
  - operand and result buffers clear to 0
  - in_ready, div_en, out_valid, busy and done go to 0; out_index goes to 0
  - reset mid-operation abandons the row; no done pulse
- div_rst equals rst combinationally. It is also driven high for exactly one cycle on start acceptance, to flush the divider pipeline.
- IDLE:
  - start=1 latches pivot and goes to LOAD; busy rises the next cycle.
  - start is ignored in all other states.
- LOAD:
  - in_ready=1; each in_valid&in_ready writes in_data to lane load_cnt and increments load_cnt.
  - The handshake on load_cnt==N-1 goes to COMPUTE. Gaps in in_valid are allowed.
- COMPUTE:
  - div_dataa and div_datab hold stable; div_en=1 for exactly DIV_LAT consecutive cycles, counted by lat_cnt.
  - After the last enabled cycle, go to CAPTURE.
  - div_en is 0 in all other states, so divider state freezes.
- CAPTURE: one cycle with div_en=0. div_result is registered into the result buffer; go to DRAIN.
- DRAIN:
  - out_valid=1, out_data=result[out_index].
  - A handshake increments out_index. out_data and out_index hold while out_ready=0.
  - The handshake at out_index==N-1 goes to DONE.
- DONE: done=1 for one cycle; out_index returns to 0; return to IDLE.
- Latency: with no stalls, the first output is valid N+DIV_LAT+2 cycles after the start cycle.
- div_dataa and div_datab are driven from registers at all times, never from in_data directly.
- N=1: LOAD and DRAIN each take one handshake; all rules above still hold.

Decomposition:
- Shared package inv_pkg holds:
  - WORD_W=27 and typedef word_t=logic[WORD_W-1:0]
  - the row_vec_t packed [N-1:0] word_t type
  - the state enum {IDLE, LOAD, COMPUTE, CAPTURE, DRAIN, DONE}
- No sub-module. The divider is instantiated alongside this block by the parent and connected through the array-divider interface's array_div modport.

Test Plan:
- Reset then idle: hold rst 3 cycles, start=0 -> all outputs 0, in_ready=0, busy=0 for 10 cycles.
- Nominal row:
  - Stimulus: pivot=27'h0000002, words 2,4,...,30 back-to-back, divider model = integer divide with DIV_LAT=6, out_ready=1.
  - Required response: div_en high exactly 6 cycles; outputs 1..15 with out_index 0..14; first out_valid at cycle 23 after start; done pulses once.
- Input gaps: in_valid toggles 1010... during LOAD -> load completes after 15 accepted words; div_dataa lane k equals word k.
- Back-pressure: out_ready low for 5 cycles at out_index=7 -> out_data and out_index hold; no word lost or duplicated; done follows index 14.
- Ignored start: start pulsed during COMPUTE with pivot=27'h7 -> latched pivot unchanged; results still use the original pivot.
- Reset mid-DRAIN: rst at out_index=4 -> next cycle IDLE, out_valid=0, no done. A new row then produces correct results from index 0.

Source files
------------

// File: rtl/inv_pkg.sv
// Shared types for the matrix-inverse datapath: word format, row vector
// and the row sequencer's state encoding.
package inv_pkg;

    localparam int WORD_W = 27;
    localparam int ROW_N  = 15;

    typedef logic [WORD_W-1:0] word_t;
    typedef word_t [ROW_N-1:0] row_vec_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        CAPTURE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/div_row_sequencer.sv
// Feeds one matrix row plus a pivot into the n-lane array divider, holds the
// operands while the divider runs for its fixed latency, captures the
// quotients and streams them back out one word at a time with back-pressure.
module div_row_sequencer
    import inv_pkg::*;
#(
    parameter int N       = ROW_N,
    parameter int W       = WORD_W,
    parameter int DIV_LAT = 6,
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [W-1:0]       pivot,
    input  logic               in_valid,
    input  logic [W-1:0]       in_data,
    output logic               in_ready,
    output logic               div_en,
    output logic               div_rst,
    output logic [N*W-1:0]     div_dataa,
    output logic [N*W-1:0]     div_datab,
    input  logic [N*W-1:0]     div_result,
    output logic               out_valid,
    output logic [W-1:0]       out_data,
    output logic [IDX_W-1:0]   out_index,
    input  logic               out_ready,
    output logic               busy,
    output logic               done
);

    localparam int LAT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(DIV_LAT - 1);

    state_t state;
    state_t next_state;

    logic [IDX_W-1:0]      load_cnt;
    logic [LAT_W-1:0]      lat_cnt;
    logic [W-1:0]          pivot_q;
    logic [N-1:0][W-1:0]   operand_q;
    logic [N-1:0][W-1:0]   result_q;
    logic                  accept_start;

    // Operands always come from registers so the divider never sees a
    // half-assembled row or a live input word.
    assign div_dataa = operand_q;
    assign div_datab = {N{pivot_q}};
    assign out_data  = result_q[out_index];

    // A start pulse also flushes whatever the divider pipeline still holds.
    assign div_rst = rst | accept_start;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and the per-state handshake and control outputs.
    always_comb begin
        next_state   = state;
        in_ready     = 1'b0;
        div_en       = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        accept_start = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept_start = 1'b1;
                    next_state   = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && load_cnt == LAST_IDX) begin
                    next_state = COMPUTE;
                end
            end
            COMPUTE: begin
                div_en = 1'b1;
                if (lat_cnt == LAST_LAT) begin
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                next_state = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && out_index == LAST_IDX) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                busy       = 1'b0;
                next_state = IDLE;
            end
        endcase
    end

    // Row assembly, latency counting, quotient capture and drain indexing.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt  <= '0;
            lat_cnt   <= '0;
            out_index <= '0;
            pivot_q   <= '0;
            operand_q <= '0;
            result_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pivot_q   <= pivot;
                        load_cnt  <= '0;
                        lat_cnt   <= '0;
                        out_index <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        operand_q[load_cnt] <= in_data;
                        if (load_cnt == LAST_IDX) begin
                            load_cnt <= '0;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (lat_cnt == LAST_LAT) begin
                        lat_cnt <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    result_q <= div_result;
                end
                DRAIN: begin
                    if (out_ready && out_index != LAST_IDX) begin
                        out_index <= out_index + 1'b1;
                    end
                end
                DONE: begin
                    out_index <= '0;
                end
                default: begin
                    load_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_row_sequencer.sv
// Directed bench for div_row_sequencer with a behavioural stand-in for the
// array divider (per-lane integer divide behind an enabled pipeline).
module tb_div_row_sequencer;

    localparam int N       = 15;
    localparam int W       = 27;
    localparam int DIV_LAT = 6;
    localparam int IDX_W   = 4;

    logic               clk;
    logic               rst;
    logic               start;
    logic [W-1:0]       pivot;
    logic               in_valid;
    logic [W-1:0]       in_data;
    logic               in_ready;
    logic               div_en;
    logic               div_rst;
    logic [N*W-1:0]     div_dataa;
    logic [N*W-1:0]     div_datab;
    logic [N*W-1:0]     div_result;
    logic               out_valid;
    logic [W-1:0]       out_data;
    logic [IDX_W-1:0]   out_index;
    logic               out_ready;
    logic               busy;
    logic               done;

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle        = 0;
    int en_count     = 0;
    int done_count   = 0;

    div_row_sequencer #(.N(N), .W(W), .DIV_LAT(DIV_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pivot      (pivot),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .div_en     (div_en),
        .div_rst    (div_rst),
        .div_dataa  (div_dataa),
        .div_datab  (div_datab),
        .div_result (div_result),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure start-to-first-output latency.
    always @(posedge clk) begin
        cycle <= cycle + 1;
    end

    // Running totals of enabled divider cycles and done pulses.
    always @(negedge clk) begin
        if (div_en) en_count <= en_count + 1;
        if (done) done_count <= done_count + 1;
    end

    // Lane-wise integer divide; a zero divisor yields all ones.
    function automatic logic [N*W-1:0] quot(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        logic [N*W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (b[k*W +: W] == '0) r[k*W +: W] = '1;
            else r[k*W +: W] = a[k*W +: W] / b[k*W +: W];
        end
        return r;
    endfunction

    // Divider stand-in: results advance only while enabled, flushed by div_rst.
    logic [N*W-1:0] pipe [DIV_LAT];
    always @(posedge clk) begin
        if (div_rst) begin
            for (int i = 0; i < DIV_LAT; i++) pipe[i] <= '0;
        end else if (div_en) begin
            pipe[0] <= quot(div_dataa, div_datab);
            for (int i = 1; i < DIV_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign div_result = pipe[DIV_LAT-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [W-1:0] data);
        in_valid = valid;
        in_data  = data;
    endtask

    task automatic waitOutValid(input int limit);
        int n;
        n = 0;
        while (!out_valid && n < limit) begin
            step();
            n++;
        end
        checkOutput("out_valid_wait", 64'(out_valid), 64'd1);
    endtask

    initial begin
        int start_cycle;
        int en_base;
        int done_base;

        rst       = 1'b1;
        start     = 1'b0;
        pivot     = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset held for three cycles, then idle with start low.
        step();
        checkOutput("div_rst_during_reset", 64'(div_rst), 64'd1);
        step();
        step();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            checkOutput("idle_in_ready", 64'(in_ready), 64'd0);
            checkOutput("idle_busy", 64'(busy), 64'd0);
            checkOutput("idle_out_valid", 64'(out_valid), 64'd0);
            checkOutput("idle_div_en", 64'(div_en), 64'd0);
            checkOutput("idle_done", 64'(done), 64'd0);
            checkOutput("idle_div_rst", 64'(div_rst), 64'd0);
            checkOutput("idle_out_index", 64'(out_index), 64'd0);
            step();
        end
        checkOutput("idle_dataa", 64'(div_dataa[W-1:0]), 64'd0);

        // Nominal row: pivot 2, words 2,4,...,30 -> quotients 1..15.
        en_base     = en_count;
        done_base   = done_count;
        start       = 1'b1;
        pivot       = 27'h0000002;
        start_cycle = cycle;
        #1;
        checkOutput("start_div_rst", 64'(div_rst), 64'd1);
        step();
        start = 1'b0;
        checkOutput("load_busy", 64'(busy), 64'd1);
        checkOutput("load_in_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < N; k++) begin
            applyStimulus(1'b1, W'(2 * (k + 1)));
            step();
        end
        applyStimulus(1'b0, '0);
        checkOutput("compute_in_ready", 64'(in_ready), 64'd0);
        checkOutput("compute_div_en", 64'(div_en), 64'd1);
        waitOutValid(40);
        checkOutput("first_out_latency", 64'(cycle - start_cycle), 64'd23);
        checkOutput("div_en_cycles", 64'(en_count - en_base), 64'd6);
        for (int i = 0; i < N; i++) begin
            checkOutput("nom_out_valid", 64'(out_valid), 64'd1);
            checkOutput("nom_out_index", 64'(out_index), 64'(i));
            checkOutput("nom_out_data", 64'(out_data), 64'(i + 1));
            step();
        end
        checkOutput("nom_done", 64'(done), 64'd1);
        checkOutput("nom_done_out_valid", 64'(out_valid), 64'd0);
        step();
        checkOutput("nom_after_done", 64'(done), 64'd0);
        checkOutput("nom_after_busy", 64'(busy), 64'd0);
        checkOutput("nom_after_index", 64'(out_index), 64'd0);
        checkOutput("nom_done_count", 64'(done_count - done_base), 64'd1);

        // Gapped input, ignored start in COMPUTE, back-pressure at index 7.
        // Pivot 3, words 3k+7 -> quotients k+2.
        done_base = done_count;
        start     = 1'b1;
        pivot     = 27'h0000003;
        step();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            applyStimulus(1'b1, W'(3 * k + 7));
            step();
            applyStimulus(1'b0, 27'h5A5A5A5);
            step();
        end
        applyStimulus(1'b0, '0);
        checkOutput("gap_in_ready", 64'(in_ready), 64'd0);
        checkOutput("gap_div_en", 64'(div_en), 64'd1);
        for (int k = 0; k < N; k++) begin
            checkOutput("gap_dataa_lane", 64'(div_dataa[k*W +: W]), 64'(3 * k + 7));
        end
        start = 1'b1;
        pivot = 27'h0000007;
        #1;
        checkOutput("ignored_start_div_rst", 64'(div_rst), 64'd0);
        step();
        start = 1'b0;
        pivot = '0;
        checkOutput("ignored_start_datab0", 64'(div_datab[W-1:0]), 64'd3);
        checkOutput("ignored_start_datab14", 64'(div_datab[14*W +: W]), 64'd3);
        waitOutValid(40);
        for (int i = 0; i < N; i++) begin
            checkOutput("bp_out_index", 64'(out_index), 64'(i));
            checkOutput("bp_out_data", 64'(out_data), 64'(i + 2));
            if (i == 7) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
                    checkOutput("bp_hold_index", 64'(out_index), 64'd7);
                    checkOutput("bp_hold_data", 64'(out_data), 64'd9);
                end
                out_ready = 1'b1;
            end
            step();
        end
        checkOutput("bp_done", 64'(done), 64'd1);
        step();
        checkOutput("bp_done_count", 64'(done_count - done_base), 64'd1);

        // Reset in the middle of draining: pivot 5, words 10k+5 -> 2k+1.
        done_base = done_count;
        start     = 1'b1;
        pivot     = 27'h0000005;
        step();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            applyStimulus(1'b1, W'(10 * k + 5));
            step();
        end
        applyStimulus(1'b0, '0);
        waitOutValid(40);
        for (int i = 0; i < 4; i++) begin
            checkOutput("rst_pre_data", 64'(out_data), 64'(2 * i + 1));
            step();
        end
        checkOutput("rst_at_index", 64'(out_index), 64'd4);
        rst = 1'b1;
        #1;
        checkOutput("rst_div_rst", 64'(div_rst), 64'd1);
        step();
        rst = 1'b0;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_out_index", 64'(out_index), 64'd0);
        step();
        step();
        checkOutput("rst_no_done", 64'(done_count - done_base), 64'd0);

        // Fresh row after the abandoned one: pivot 1, words 100k+1.
        start = 1'b1;
        pivot = 27'h0000001;
        step();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            applyStimulus(1'b1, W'(100 * k + 1));
            step();
        end
        applyStimulus(1'b0, '0);
        waitOutValid(40);
        for (int i = 0; i < N; i++) begin
            checkOutput("post_rst_index", 64'(out_index), 64'(i));
            checkOutput("post_rst_data", 64'(out_data), 64'(100 * i + 1));
            step();
        end
        checkOutput("post_rst_done", 64'(done), 64'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
